// File: rtl/reg_file_arbiter_pkg.sv
// Shared constants and types for the register-file arbiter slice.
package reg_file_arb_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2**ADDR_W;

  typedef enum logic {SCRUB, RUN} state_t;
endpackage

// File: rtl/reg_file_arbiter_if.sv
// Client request/response bus plus register-file port bundle seen by the arbiter.
interface reg_file_arbiter_if #(
  parameter int unsigned DATA_W = reg_file_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_arb_pkg::ADDR_W
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_rd;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_rd0_addr;
  logic [2*ADDR_W-1:0] req_rd1_addr;
  logic [2*ADDR_W-1:0] req_wr_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data0;
  logic [DATA_W-1:0]   rsp_data1;
  logic                scrub_done;
  logic                rf_wr_en;
  logic                rf_rd_en;
  logic [ADDR_W-1:0]   rf_rd0_addr;
  logic [ADDR_W-1:0]   rf_rd1_addr;
  logic [ADDR_W-1:0]   rf_wr0_addr;
  logic [DATA_W-1:0]   rf_wr0_data;
  logic [DATA_W-1:0]   rf_rd0_data;
  logic [DATA_W-1:0]   rf_rd1_data;

  modport master (
    output req_valid, req_rd, req_we, req_rd0_addr, req_rd1_addr, req_wr_addr, req_wdata,
    output rf_rd0_data, rf_rd1_data,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1, scrub_done,
    input  rf_wr_en, rf_rd_en, rf_rd0_addr, rf_rd1_addr, rf_wr0_addr, rf_wr0_data
  );

  modport slave (
    input  req_valid, req_rd, req_we, req_rd0_addr, req_rd1_addr, req_wr_addr, req_wdata,
    input  rf_rd0_data, rf_rd1_data,
    output req_ready, rsp_valid, rsp_data0, rsp_data1, scrub_done,
    output rf_wr_en, rf_rd_en, rf_rd0_addr, rf_rd1_addr, rf_wr0_addr, rf_wr0_data
  );
endinterface

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the other side after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);
  logic r_prio;  // 0: requester 0 wins a tie, 1: requester 1 wins

  always_comb begin
    o_grant = '0;
    if (i_en) begin
      if (i_valid == 2'b11) o_grant = r_prio ? 2'b10 : 2'b01;
      else                  o_grant = i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_prio <= 1'b0;
    else if (|o_grant)  r_prio <= ~o_grant[1];
  end
endmodule

// File: rtl/reg_file_arbiter.sv
// Scrubs the register file after reset, then shares it round-robin between two clients.
module reg_file_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int unsigned DATA_W = reg_file_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_arb_pkg::ADDR_W
) (
  input logic               clk,
  input logic               rst,
  reg_file_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2**ADDR_W - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_scrub_cnt;
  logic [1:0]          r_rd_pend;
  logic [1:0]          r_rsp_valid;
  logic                r_scrub_done;
  logic                r_wr_en;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd0_addr;
  logic [ADDR_W-1:0]   r_rd1_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic                w_arb_en;
  logic [1:0]          w_grant;
  logic [1:0]          w_xfer;
  logic                w_sel;
  logic                w_rd;
  logic                w_we;
  logic [ADDR_W-1:0]   w_rd0_addr;
  logic [ADDR_W-1:0]   w_rd1_addr;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_arb_en = (r_state == RUN) && !rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_arb_en),
    .i_valid (bus.req_valid),
    .o_grant (w_grant)
  );

  assign w_xfer = bus.req_valid & w_grant;

  always_comb begin
    w_sel      = w_grant[1];
    w_rd       = bus.req_rd[w_sel];
    w_we       = bus.req_we[w_sel];
    w_rd0_addr = w_sel ? bus.req_rd0_addr[2*ADDR_W-1:ADDR_W] : bus.req_rd0_addr[ADDR_W-1:0];
    w_rd1_addr = w_sel ? bus.req_rd1_addr[2*ADDR_W-1:ADDR_W] : bus.req_rd1_addr[ADDR_W-1:0];
    w_wr_addr  = w_sel ? bus.req_wr_addr[2*ADDR_W-1:ADDR_W]  : bus.req_wr_addr[ADDR_W-1:0];
    w_wdata    = w_sel ? bus.req_wdata[2*DATA_W-1:DATA_W]    : bus.req_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SCRUB;
      r_scrub_cnt  <= '0;
      r_rd_pend    <= '0;
      r_rsp_valid  <= '0;
      r_scrub_done <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd0_addr   <= '0;
      r_rd1_addr   <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      // Read data leaves the file one cycle after rf_rd_en, so the owner tag trails by two stages.
      r_rsp_valid <= r_rd_pend;
      r_rd_pend   <= w_xfer & bus.req_rd;
      case (r_state)
        SCRUB: begin
          r_wr_en     <= 1'b1;
          r_wr_addr   <= r_scrub_cnt;
          r_wr_data   <= '0;
          r_scrub_cnt <= r_scrub_cnt + 1'b1;
          if (r_scrub_cnt == LAST_ADDR) begin
            r_state      <= RUN;
            r_scrub_done <= 1'b1;
          end
        end
        RUN: begin
          if (|w_xfer) begin
            r_wr_en <= w_we;
            r_rd_en <= w_rd;
            if (w_we) begin
              r_wr_addr <= w_wr_addr;
              r_wr_data <= w_wdata;
            end
            if (w_rd) begin
              r_rd0_addr <= w_rd0_addr;
              r_rd1_addr <= w_rd1_addr;
            end
          end
        end
        default: r_state <= SCRUB;
      endcase
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data0   = bus.rf_rd0_data;
  assign bus.rsp_data1   = bus.rf_rd1_data;
  assign bus.scrub_done  = r_scrub_done;
  assign bus.rf_wr_en    = r_wr_en;
  assign bus.rf_rd_en    = r_rd_en;
  assign bus.rf_rd0_addr = r_rd0_addr;
  assign bus.rf_rd1_addr = r_rd1_addr;
  assign bus.rf_wr0_addr = r_wr_addr;
  assign bus.rf_wr0_data = r_wr_data;
endmodule
